// File: rtl/sort_frame_sequencer_if.sv
// Host-side handshake bundle for the sort frame sequencer: pixel intake,
// sorted-index readout and frame status.
interface sort_frame_sequencer_if #(
    parameter int ADDR_W  = 14,
    parameter int FRAME_W = 8
);
    logic               start;
    logic               abort;
    logic               pix_valid;
    logic               pix_ready;
    logic [ADDR_W-1:0]  pix_addr;
    logic               index_valid;
    logic               busy;
    logic               in_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_addr;
    logic               done;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output start, abort, pix_valid, out_ready,
        input  pix_ready, pix_addr, index_valid, busy, in_valid, out_addr, done, frame_cnt
    );

    modport slave (
        input  start, abort, pix_valid, out_ready,
        output pix_ready, pix_addr, index_valid, busy, in_valid, out_addr, done, frame_cnt
    );
endinterface

// File: rtl/sort_frame_sequencer.sv
// Frame-level controller for the sorting engine: loads one frame of pixels,
// waits out the sorter pipeline, then streams the sorted indices downstream.
module sort_frame_sequencer #(
    parameter int NUM_PIX    = 16384,
    parameter int PIPE_DEPTH = 16,
    parameter int ADDR_W     = 14,
    parameter int FRAME_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_frame_sequencer_if.slave bus
);
    localparam int FLUSH_W = 5;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_PIX - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(PIPE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pix_addr;
    logic [ADDR_W-1:0]  out_addr;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               pix_ready;
    logic               index_valid;
    logic               busy;
    logic               in_valid;
    logic               done;

    // Every status output is registered alongside the state so that it
    // changes on the same edge as the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pix_addr    <= '0;
            out_addr    <= '0;
            flush_cnt   <= '0;
            frame_cnt   <= '0;
            pix_ready   <= 1'b0;
            index_valid <= 1'b0;
            busy        <= 1'b0;
            in_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            done        <= 1'b0;
            if (bus.abort && state != IDLE) begin
                state     <= IDLE;
                pix_addr  <= '0;
                out_addr  <= '0;
                flush_cnt <= '0;
                pix_ready <= 1'b0;
                busy      <= 1'b0;
                in_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state       <= LOAD;
                            pix_addr    <= '0;
                            out_addr    <= '0;
                            flush_cnt   <= '0;
                            pix_ready   <= 1'b1;
                            index_valid <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // pix_ready is high throughout LOAD, so pix_valid alone marks an accept.
                        if (bus.pix_valid) begin
                            if (pix_addr == LAST_ADDR) begin
                                pix_addr  <= '0;
                                flush_cnt <= '0;
                                state     <= FLUSH;
                                pix_ready <= 1'b0;
                                busy      <= 1'b1;
                            end else begin
                                pix_addr <= pix_addr + ADDR_W'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == LAST_FLUSH) begin
                            flush_cnt <= '0;
                            state     <= EMIT;
                            in_valid  <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt + FLUSH_W'(1);
                        end
                    end
                    EMIT: begin
                        if (bus.out_ready) begin
                            if (out_addr == LAST_ADDR) begin
                                out_addr <= '0;
                                state    <= DONE;
                                busy     <= 1'b0;
                                in_valid <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                out_addr <= out_addr + ADDR_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.pix_addr    = pix_addr;
    assign bus.index_valid = index_valid;
    assign bus.busy        = busy;
    assign bus.in_valid    = in_valid;
    assign bus.out_addr    = out_addr;
    assign bus.done        = done;
    assign bus.frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Directed bench for sort_frame_sequencer: a 16-pixel instance for the frame
// timeline, backpressure, abort and reset cases, plus a full-size instance for latency.
module tb_sort_frame_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    sort_frame_sequencer_if #(.ADDR_W(4), .FRAME_W(2)) bus ();
    sort_frame_sequencer_if #(.ADDR_W(14), .FRAME_W(8)) bus_big ();

    sort_frame_sequencer #(.NUM_PIX(16), .PIPE_DEPTH(4), .ADDR_W(4), .FRAME_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sort_frame_sequencer #(.NUM_PIX(16384), .PIPE_DEPTH(16), .ADDR_W(14), .FRAME_W(8)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs();
        return {bus.pix_ready, bus.index_valid, bus.busy, bus.in_valid, bus.done,
                bus.pix_addr, bus.out_addr};
    endfunction

    function automatic logic [12:0] mk(input logic pr, input logic iv, input logic b,
                                       input logic v, input logic d, input int pa, input int oa);
        logic [3:0] pa4;
        logic [3:0] oa4;
        pa4 = 4'(pa);
        oa4 = 4'(oa);
        return {pr, iv, b, v, d, pa4, oa4};
    endfunction

    // Continuous handshake frame; a stray start in LOAD must be ignored.
    task automatic run_frame(input logic [1:0] fc_exp, input string tag);
        logic pr, b, v;
        bus.start     = 1'b1;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            step();
            bus.start = (c == 5);
            pr = (c >= 1 && c <= 16);
            b  = (c >= 17 && c <= 36);
            v  = (c >= 21 && c <= 36);
            chk($sformatf("%s_c%0d", tag, c), 32'(obs()),
                32'(mk(pr, c == 1, b, v, c == 37, pr ? c - 1 : 0, v ? c - 21 : 0)));
        end
        bus.start = 1'b0;
        chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(fc_exp));
    endtask

    initial begin
        int seq;
        int load_c, busy_c, valid_c, done_c;
        logic pr, b, v;
        n_chk  = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;  bus.pix_valid = 1'b0;  bus.out_ready = 1'b0;
        bus_big.start = 1'b0;  bus_big.abort = 1'b0;
        bus_big.pix_valid = 1'b0;  bus_big.out_ready = 1'b0;
        step();
        step();
        chk("reset_outputs", 32'(obs()), 32'(0));
        chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'(0));
        rst = 1'b0;
        step();

        // start together with abort in IDLE stays in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_start", 32'(obs()), 32'(0));

        run_frame(2'd1, "full");

        // pix_valid toggling 1,0,1,0: accepts on odd cycles only
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 53; c++) begin
            step();
            bus.start     = 1'b0;
            bus.pix_valid = c[0];
            if (c <= 52) begin
                pr = (c <= 31);
                b  = (c >= 32 && c <= 51);
                v  = (c >= 36 && c <= 51);
                chk($sformatf("toggle_c%0d", c), 32'(obs()),
                    32'(mk(pr, c == 1, b, v, c == 52, pr ? c / 2 : 0, v ? c - 36 : 0)));
            end else begin
                chk("toggle_frame_cnt", 32'(bus.frame_cnt), 32'(2));
            end
        end

        // out_ready low for 5 cycles while out_addr is 7
        bus.start     = 1'b1;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        seq = 0;
        for (int c = 1; c <= 43; c++) begin
            step();
            bus.start     = 1'b0;
            bus.out_ready = !(c >= 28 && c <= 32);
            if (c >= 21 && c <= 41) begin
                chk($sformatf("bp_c%0d", c), 32'({bus.in_valid, bus.busy, bus.out_addr}),
                    32'({2'b11, 4'(seq)}));
                if (bus.out_ready) seq++;
            end else if (c == 42) begin
                chk("bp_done", 32'({bus.done, bus.in_valid}), 32'(2'b10));
                chk("bp_count", 32'(seq), 32'(16));
            end else if (c == 43) begin
                chk("bp_frame_cnt", 32'(bus.frame_cnt), 32'(3));
            end
        end

        // abort in LOAD at pix_addr 9, with a simultaneous accept
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.start = 1'b0;
        end
        chk("abort_load_addr", 32'(bus.pix_addr), 32'(9));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_load_out", 32'(obs()), 32'(0));
        chk("abort_load_fc", 32'(bus.frame_cnt), 32'(3));
        step();
        chk("abort_load_idle", 32'(obs()), 32'(0));

        // abort on the second FLUSH cycle
        bus.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            bus.start = 1'b0;
        end
        chk("abort_flush_busy", 32'({bus.busy, bus.pix_ready, bus.in_valid}), 32'(3'b100));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_flush_out", 32'(obs()), 32'(0));
        chk("abort_flush_fc", 32'(bus.frame_cnt), 32'(3));

        run_frame(2'd0, "post_abort");
        run_frame(2'd1, "wrap");

        // asynchronous reset in the middle of EMIT, away from any clock edge
        bus.start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            bus.start = 1'b0;
        end
        chk("pre_rst_emit", 32'({bus.in_valid, bus.out_addr}), 32'({1'b1, 4'd4}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(obs()), 32'(0));
        chk("async_rst_fc", 32'(bus.frame_cnt), 32'(0));
        #1;
        rst = 1'b0;
        step();
        run_frame(2'd1, "after_rst");

        // full-size instance, continuous handshake
        load_c = -1;  busy_c = -1;  valid_c = -1;  done_c = -1;
        bus_big.start     = 1'b1;
        bus_big.pix_valid = 1'b1;
        bus_big.out_ready = 1'b1;
        for (int c = 1; c <= 40000 && done_c < 0; c++) begin
            step();
            bus_big.start = 1'b0;
            if (load_c  < 0 && bus_big.pix_ready) load_c  = c;
            if (busy_c  < 0 && bus_big.busy)      busy_c  = c;
            if (valid_c < 0 && bus_big.in_valid)  valid_c = c;
            if (done_c  < 0 && bus_big.done)      done_c  = c;
        end
        step();
        chk("big_load_entry", 32'(load_c), 32'(1));
        chk("big_busy_latency", 32'(busy_c - load_c), 32'(16384));
        chk("big_flush_len", 32'(valid_c - busy_c), 32'(16));
        chk("big_emit_len", 32'(done_c - valid_c), 32'(16384));
        chk("big_frame_cnt", 32'(bus_big.frame_cnt), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
